// File: rtl/mem_port_pkg.sv
// Shared types and constants for the multi-cycle core's memory-access stage.
package mem_port_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int TIMEOUT_DEFAULT = 64;
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 5;
endpackage

// File: rtl/mem_wdog.sv
// Request watchdog: counts cycles while enabled, flags expiry at TIMEOUT-1.
module mem_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + CW'(1);
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port.sv
// Memory-access stage: issues req/ack transactions for fetch/load/store,
// owns IR and MDR, and stalls the control FSM until the access completes.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irwrite,
    input  logic             iord,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] wd,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic [WIDTH-1:0] data,
    output logic             stall,
    output logic             err
);
    state_t state;
    logic   is_fetch;
    logic   is_store;
    logic   trigger;
    logic   expired;

    assign trigger = irwrite | iord;

    mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE),
        .enable  (state == REQ),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            instr     <= '0;
            data      <= '0;
            err       <= 1'b0;
            is_fetch  <= 1'b0;
            is_store  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        mem_addr  <= iord ? aluout : pc;
                        mem_we    <= memwrite;
                        mem_wdata <= wd;
                        is_fetch  <= irwrite;
                        is_store  <= memwrite;
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the final watchdog cycle still completes the access.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (is_fetch)
                            instr <= mem_rdata;
                        else if (!is_store)
                            data <= mem_rdata;
                    end else if (expired) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Only trigger reaches stall combinationally; everything else is registered.
    assign stall = ((state == IDLE) && trigger) || (state == REQ);
    assign op    = instr[OP_HI:OP_LO];
    assign funct = instr[FUNCT_HI:0];
endmodule

// File: doc/mem_port.md
# mem_port

Memory-access stage for the multi-cycle MIPS core. It sits between the main decoder's memory controls (irwrite, iord, memwrite) and a variable-latency word memory with a req/ack handshake. It owns the instruction register (IR), which feeds op/funct back to the main decoder, and the memory data register (MDR). It raises stall so the control FSM holds its state until the access completes.

## Interface
- WIDTH, 32: address and data width.
- TIMEOUT, 64: maximum cycles in REQ before the access aborts; must be ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- irwrite  in  1  decoder: instruction fetch; capture read data into IR.
- iord  in  1  decoder: address select; 0 = pc, 1 = aluout. Also marks a data access.
- memwrite  in  1  decoder: the access is a store.
- pc  in  WIDTH  fetch address.
- aluout  in  WIDTH  data address.
- wd  in  WIDTH  store data.
- mem_req  out  1  request valid.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  WIDTH  request address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data, valid when mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse.
- instr  out  WIDTH  IR contents.
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- data  out  WIDTH  MDR contents.
- stall  out  1  FSM must hold state; the datapath gates pcwrite/regwrite with ~stall.
- err  out  1  sticky timeout flag.

## Operation
- trigger = irwrite | iord. A store is trigger & memwrite; everything else is a read.
- States: IDLE, REQ, DONE.
- IDLE:
  - On trigger, latch the request and go to REQ.
  - Latched values: mem_addr = iord ? aluout : pc; mem_we = memwrite; mem_wdata = wd; plus the kind flags is_fetch = irwrite and is_store = memwrite.
  - Clear the timeout counter.
- REQ:
  - mem_req = 1. mem_addr, mem_we and mem_wdata stay stable.
  - On mem_ack → DONE and drop mem_req:
    - a fetch loads IR from mem_rdata;
    - a non-fetch read loads MDR;
    - a store captures nothing.
  - If no ack arrives, the counter increments each cycle. When it reaches TIMEOUT-1 → DONE, drop mem_req, capture nothing, set err.
- DONE: exactly one cycle with stall = 0, so the FSM advances. Trigger is ignored here. Then → IDLE.
- stall = (IDLE & trigger) | REQ. The only combinational input path to stall is from trigger.
- mem_ack outside REQ is ignored.
- err clears only on reset.
- Back-to-back access states (store followed by fetch): DONE separates them, and the new trigger is seen in IDLE on the following cycle. No access is ever issued twice for one FSM state.

## Timing
- Reset values:
  - state = IDLE
  - mem_req = 0, mem_we = 0
  - mem_addr = 0, mem_wdata = 0
  - instr = 0 (so op = 0), data = 0
  - err = 0
- Reset assertion mid-access drops mem_req immediately (asynchronously). A later ack is ignored.
- Latency with ack in the first REQ cycle: trigger seen at cycle t, mem_req high at t+1, ack at t+1, DONE at t+2, FSM advances at the end of t+2. An access state therefore lasts at least 3 cycles; each extra ack-wait cycle adds 1.
- IR and MDR are updated on the edge that ends the ack cycle and are valid in DONE.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then DONE.

## Structure
- Package mem_port_pkg:
  - state encoding: IDLE = 2'b00, REQ = 2'b01, DONE = 2'b10;
  - TIMEOUT default;
  - opcode-field bit positions (OP_HI = 31, OP_LO = 26, FUNCT_HI = 5).
- One sub-module, mem_wdog: a $clog2(TIMEOUT)-bit counter with clear/enable inputs and an expired output. It is instantiated once.

## Test plan
- Fetch, 0-wait: pc = 0x0000_0040, irwrite = 1, ack in the first REQ cycle with rdata = 0x8C08_0004 → mem_addr = 0x40, mem_we = 0, stall high 2 cycles, instr = 0x8C08_0004 in DONE, op = 6'b100011.
- Load, 3-wait: iord = 1, aluout = 0x100, ack on the 4th REQ cycle with rdata = 0xDEAD_BEEF → data = 0xDEAD_BEEF, IR unchanged, stall high 5 cycles.
- Store then fetch: memwrite = iord = 1, wd = 0x1234_5678, then irwrite = 1 at pc = 0x44:
  - the first request has mem_we = 1, mem_wdata = 0x1234_5678;
  - DONE lasts one cycle;
  - the second request has mem_we = 0, mem_addr = 0x44;
  - MDR is unchanged throughout.
- Timeout: TIMEOUT = 4, never ack → mem_req high exactly 4 cycles, err = 1 sticky, IR/MDR unchanged. A stray ack afterwards is ignored.
- Reset mid-REQ: reset low during REQ → mem_req = 0 at once, instr = 0, err = 0. A subsequent ack has no effect.
- No trigger: irwrite = iord = 0 for 10 cycles → stall = 0, mem_req = 0 throughout.
